// File: rtl/fifo_credit_sender.sv
// rtl/fifo_credit_sender.sv - pops the upstream FIFO onto a registered link, gated by remote credits
module fifo_credit_sender #(
    parameter int W       = 33,
    parameter int CREDITS = 62,
    parameter int CW      = 6,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [W-1:0]    fifo_dout,
    input  logic            fifo_valid,
    output logic            fifo_deq,
    output logic [W-1:0]    link_data,
    output logic            link_enq,
    input  logic            credit_in,
    output logic [CW-1:0]   credits,
    output logic [CNTW-1:0] sent_count,
    output logic            idle,
    output logic            credit_err
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    state_t        state;
    state_t        state_next;
    logic          pop;
    logic [CW-1:0] credits_next;
    logic          err_set;
    logic          idle_next;

    always_comb begin
        state_next   = state;
        fifo_deq     = 1'b0;
        pop          = 1'b0;
        credits_next = credits;
        err_set      = 1'b0;
        idle_next    = 1'b0;

        case (state)
            ST_INIT:  state_next = en ? ST_RUN : ST_PAUSE;
            ST_RUN:   if (!en) state_next = ST_PAUSE;
            ST_PAUSE: if (en) state_next = ST_RUN;
            default:  state_next = ST_INIT;
        endcase

        // A credit returned this cycle is not usable until the next one.
        fifo_deq = (state == ST_RUN) && (credits != '0);
        pop      = fifo_deq && fifo_valid;

        if (pop && !credit_in) begin
            credits_next = credits - CW'(1);
        end else if (!pop && credit_in && (credits != CRED_MAX)) begin
            credits_next = credits + CW'(1);
        end

        err_set   = credit_in && (credits == CRED_MAX);
        idle_next = (credits_next == CRED_MAX) && !pop && (state_next != ST_INIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_INIT;
            credits    <= CRED_MAX;
            sent_count <= '0;
            credit_err <= 1'b0;
            link_enq   <= 1'b0;
            link_data  <= '0;
            idle       <= 1'b0;
        end else begin
            state    <= state_next;
            credits  <= credits_next;
            link_enq <= pop;
            idle     <= idle_next;
            if (pop) begin
                link_data  <= fifo_dout;
                sent_count <= sent_count + CNTW'(1);
            end
            if (err_set) begin
                credit_err <= 1'b1;
            end
        end
    end

    a_credit_range: assert property (@(posedge clk) disable iff (rst) credits <= CRED_MAX);

endmodule
